axi_mem_responder: RTL and testbench

Word-organised memory that serves the responder side of the core's AXI-lite-style bus: AR/R for instruction fetch and loads, AW/W/B for stores. It replaces ideal memory in simulation and SQED verification harnesses and connects directly to the core's memory-interface master. Read and write engines are independent FSMs with programmable wait states, so the bench can exercise every master stall path.

---
 rtl/axi_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_mem_responder                                                          |
// | Word memory serving AXI-lite-style AR/R and AW/W/B with programmable waits. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int READ_WAIT  = 0,
   parameter int WRITE_WAIT = 0
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        ARvalid,
   output logic        ARready,
   input  logic [31:0] ARdata,
   input  logic [2:0]  arprot,
   output logic        Rvalid,
   input  logic        RReady,
   output logic [31:0] Rdata,
   input  logic        AWvalid,
   output logic        AWready,
   input  logic [31:0] AWdata,
   input  logic [2:0]  awprot,
   input  logic        Wvalid,
   output logic        Wready,
   input  logic [31:0] Wdata,
   input  logic [3:0]  Wstrb,
   output logic        Bvalid,
   input  logic        Bready
);
   localparam int         DEPTH        = 1 << ADDR_WIDTH;
   localparam logic [3:0] C_READ_WAIT  = 4'(READ_WAIT);
   localparam logic [3:0] C_WRITE_WAIT = 4'(WRITE_WAIT);

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_t;
   typedef enum logic [1:0] {W_COLLECT = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wstate_t;

   logic [31:0] mem [DEPTH];

   rstate_t               rstate_q, rstate_d;
   logic [3:0]            rcnt_q, rcnt_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  run_q;

   wstate_t               wstate_q, wstate_d;
   logic [3:0]            wcnt_q, wcnt_d;
   logic                  aw_got_q, aw_got_d, w_got_q, w_got_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;

   logic                  ar_hs, aw_hs, w_hs, commit;
   logic [ADDR_WIDTH-1:0] commit_addr;
   logic [31:0]           commit_data;
   logic [3:0]            commit_strb;
   logic                  unused_inputs;

   // run_q keeps every ready low for the cycle after reset is sampled
   assign ARready = run_q && (rstate_q == R_IDLE);
   assign AWready = run_q && (wstate_q == W_COLLECT) && !aw_got_q;
   assign Wready  = run_q && (wstate_q == W_COLLECT) && !w_got_q;
   assign Rvalid  = (rstate_q == R_DATA);
   assign Bvalid  = (wstate_q == W_RESP);
   assign Rdata   = rdata_q;

   assign ar_hs = ARvalid && ARready;
   assign aw_hs = AWvalid && AWready;
   assign w_hs  = Wvalid && Wready;

   assign commit_addr = aw_got_q ? waddr_q : AWdata[ADDR_WIDTH+1:2];
   assign commit_data = w_got_q ? wdata_q : Wdata;
   assign commit_strb = w_got_q ? wstrb_q : Wstrb;
   assign commit      = resetn && (wstate_q == W_COLLECT) &&
                        (aw_got_q || aw_hs) && (w_got_q || w_hs);

   assign unused_inputs = ^{arprot, awprot, ARdata[31:ADDR_WIDTH+2], ARdata[1:0],
                            AWdata[31:ADDR_WIDTH+2], AWdata[1:0]};

   always_comb begin
      rstate_d = rstate_q;
      rcnt_d   = rcnt_q;
      raddr_d  = raddr_q;
      rdata_d  = rdata_q;
      case (rstate_q)
         R_IDLE: begin
            if (ar_hs) begin
               raddr_d = ARdata[ADDR_WIDTH+1:2];
               rcnt_d  = C_READ_WAIT;
               if (READ_WAIT == 0) begin
                  rstate_d = R_DATA;
                  rdata_d  = mem[ARdata[ADDR_WIDTH+1:2]];
               end else begin
                  rstate_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (rcnt_q == 4'd1) begin
               rstate_d = R_DATA;
               rdata_d  = mem[raddr_q];
            end else begin
               rcnt_d = rcnt_q - 4'd1;
            end
         end
         R_DATA: begin
            if (RReady) rstate_d = R_IDLE;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      wstate_d = wstate_q;
      wcnt_d   = wcnt_q;
      aw_got_d = aw_got_q;
      w_got_d  = w_got_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      case (wstate_q)
         W_COLLECT: begin
            if (aw_hs) begin
               aw_got_d = 1'b1;
               waddr_d  = AWdata[ADDR_WIDTH+1:2];
            end
            if (w_hs) begin
               w_got_d = 1'b1;
               wdata_d = Wdata;
               wstrb_d = Wstrb;
            end
            if (commit) begin
               wcnt_d   = C_WRITE_WAIT;
               wstate_d = (WRITE_WAIT == 0) ? W_RESP : W_WAIT;
            end
         end
         W_WAIT: begin
            if (wcnt_q == 4'd1) wstate_d = W_RESP;
            else                wcnt_d   = wcnt_q - 4'd1;
         end
         W_RESP: begin
            if (Bready) begin
               aw_got_d = 1'b0;
               w_got_d  = 1'b0;
               wstate_d = W_COLLECT;
            end
         end
         default: wstate_d = W_COLLECT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         rstate_q <= R_IDLE;
         rcnt_q   <= '0;
         raddr_q  <= '0;
         rdata_q  <= '0;
         run_q    <= 1'b0;
         wstate_q <= W_COLLECT;
         wcnt_q   <= '0;
         aw_got_q <= 1'b0;
         w_got_q  <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
      end else begin
         rstate_q <= rstate_d;
         rcnt_q   <= rcnt_d;
         raddr_q  <= raddr_d;
         rdata_q  <= rdata_d;
         run_q    <= 1'b1;
         wstate_q <= wstate_d;
         wcnt_q   <= wcnt_d;
         aw_got_q <= aw_got_d;
         w_got_q  <= w_got_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
      end
   end

   // Memory is deliberately not reset; a same-edge read capture sees the old word
   always_ff @(posedge clock) begin
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (commit_strb[b]) mem[commit_addr][8*b +: 8] <= commit_data[8*b +: 8];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_mem_responder                                                       |
// | Directed self-checking bench: zero-wait and waited responder instances.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi_mem_responder;
   logic clock, resetn;

   logic        ARvalid, ARready, Rvalid, RReady, AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
   logic [31:0] ARdata, Rdata, AWdata, Wdata;
   logic [3:0]  Wstrb;

   logic        b_arvalid, b_arready, b_rvalid, b_rready, b_awvalid, b_awready;
   logic        b_wvalid, b_wready, b_bvalid, b_bready;
   logic [31:0] b_ardata, b_rdata, b_awdata, b_wdata;
   logic [3:0]  b_wstrb;

   int n_checks = 0;
   int n_errors = 0;

   axi_mem_responder #(.ADDR_WIDTH(10), .READ_WAIT(0), .WRITE_WAIT(0)) dut_a (
      .clock(clock), .resetn(resetn),
      .ARvalid(ARvalid), .ARready(ARready), .ARdata(ARdata), .arprot(3'd0),
      .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
      .AWvalid(AWvalid), .AWready(AWready), .AWdata(AWdata), .awprot(3'd0),
      .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata), .Wstrb(Wstrb),
      .Bvalid(Bvalid), .Bready(Bready)
   );

   axi_mem_responder #(.ADDR_WIDTH(10), .READ_WAIT(3), .WRITE_WAIT(2)) dut_b (
      .clock(clock), .resetn(resetn),
      .ARvalid(b_arvalid), .ARready(b_arready), .ARdata(b_ardata), .arprot(3'd0),
      .Rvalid(b_rvalid), .RReady(b_rready), .Rdata(b_rdata),
      .AWvalid(b_awvalid), .AWready(b_awready), .AWdata(b_awdata), .awprot(3'd0),
      .Wvalid(b_wvalid), .Wready(b_wready), .Wdata(b_wdata), .Wstrb(b_wstrb),
      .Bvalid(b_bvalid), .Bready(b_bready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      AWvalid = 1'b1; AWdata = a; Wvalid = 1'b1; Wdata = d; Wstrb = s;
      n = 0;
      while (!(AWready && Wready) && n < 20) begin tick(); n++; end
      tick();
      AWvalid = 1'b0; Wvalid = 1'b0;
      n = 0;
      while (!Bvalid && n < 20) begin tick(); n++; end
      chk("wr_bvalid", 32'(Bvalid), 32'd1);
      Bready = 1'b1; tick(); Bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      int n;
      ARvalid = 1'b1; ARdata = a;
      n = 0;
      while (!ARready && n < 20) begin tick(); n++; end
      tick();
      ARvalid = 1'b0;
      n = 0;
      while (!Rvalid && n < 20) begin tick(); n++; end
      chk("rd_rvalid", 32'(Rvalid), 32'd1);
      d = Rdata;
      RReady = 1'b1; tick(); RReady = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      resetn = 1'b0;
      ARvalid = 0; ARdata = 0; RReady = 0; AWvalid = 0; AWdata = 0;
      Wvalid = 0; Wdata = 0; Wstrb = 0; Bready = 0;
      b_arvalid = 0; b_ardata = 0; b_rready = 0; b_awvalid = 0; b_awdata = 0;
      b_wvalid = 0; b_wdata = 0; b_wstrb = 0; b_bready = 0;

      repeat (3) tick();
      chk("rst_ctrl_a", 32'({ARready, AWready, Wready, Rvalid, Bvalid}), 32'd0);
      chk("rst_rdata_a", Rdata, 32'd0);
      resetn = 1'b1;
      tick();
      chk("post_rst_rdy_a", 32'({ARready, AWready, Wready}), 32'b111);
      chk("post_rst_rdy_b", 32'({b_arready, b_awready, b_wready}), 32'b111);

      // zero-wait read with master stalling on RReady
      do_write(32'h0C, 32'hDEADBEEF, 4'hF);
      ARvalid = 1'b1; ARdata = 32'h0C;
      chk("ar_ready_idle", 32'(ARready), 32'd1);
      tick();
      ARvalid = 1'b0;
      chk("r0_rvalid", 32'(Rvalid), 32'd1);
      chk("r0_rdata", Rdata, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("r0_stall_data", Rdata, 32'hDEADBEEF);
         chk("r0_stall_ctl", 32'({ARready, Rvalid}), 32'b01);
      end
      RReady = 1'b1; tick(); RReady = 1'b0;
      chk("r0_after_hs", 32'({ARready, Rvalid}), 32'b10);

      // AW two cycles ahead of W
      AWvalid = 1'b1; AWdata = 32'h10;
      tick();
      AWvalid = 1'b0;
      chk("aw_only_ctl", 32'({AWready, Wready, Bvalid}), 32'b010);
      tick();
      Wvalid = 1'b1; Wdata = 32'h11223344; Wstrb = 4'hF;
      tick();
      Wvalid = 1'b0;
      chk("w_late_bvalid", 32'({AWready, Wready, Bvalid}), 32'b001);
      Bready = 1'b1; tick(); Bready = 1'b0;
      chk("b_after_hs", 32'({AWready, Wready, Bvalid}), 32'b110);
      do_read(32'h10, rd);
      chk("rd_0x10", rd, 32'h11223344);

      // W ahead of AW
      Wvalid = 1'b1; Wdata = 32'hCAFEF00D; Wstrb = 4'hF;
      tick();
      Wvalid = 1'b0;
      chk("w_only_ctl", 32'({AWready, Wready, Bvalid}), 32'b100);
      AWvalid = 1'b1; AWdata = 32'h30;
      tick();
      AWvalid = 1'b0;
      chk("aw_late_bvalid", 32'(Bvalid), 32'd1);
      Bready = 1'b1; tick(); Bready = 1'b0;
      do_read(32'h30, rd);
      chk("rd_0x30", rd, 32'hCAFEF00D);

      // byte lane strobes
      do_write(32'h20, 32'hAAAAAAAA, 4'hF);
      do_write(32'h20, 32'h55555555, 4'b0100);
      do_read(32'h20, rd);
      chk("strb_0100", rd, 32'hAA55AAAA);
      do_write(32'h20, 32'h55555555, 4'b1100);
      do_read(32'h20, rd);
      chk("strb_1100", rd, 32'h5555AAAA);
      do_write(32'h20, 32'h55555555, 4'b0000);
      do_read(32'h20, rd);
      chk("strb_0000", rd, 32'h5555AAAA);

      // same-edge write commit and read capture on word 5
      do_write(32'h14, 32'h1, 4'hF);
      ARvalid = 1'b1; ARdata = 32'h14;
      AWvalid = 1'b1; AWdata = 32'h14; Wvalid = 1'b1; Wdata = 32'h2; Wstrb = 4'hF;
      tick();
      ARvalid = 1'b0; AWvalid = 1'b0; Wvalid = 1'b0;
      chk("coll_ctl", 32'({Rvalid, Bvalid}), 32'b11);
      chk("coll_old", Rdata, 32'h1);
      RReady = 1'b1; Bready = 1'b1; tick(); RReady = 1'b0; Bready = 1'b0;
      do_read(32'h14, rd);
      chk("coll_new", rd, 32'h2);
      do_read(32'h1014, rd);
      chk("alias", rd, 32'h2);

      // waited instance: WRITE_WAIT=2 then READ_WAIT=3
      b_awvalid = 1'b1; b_awdata = 32'h8; b_wvalid = 1'b1; b_wdata = 32'h600DF00D; b_wstrb = 4'hF;
      tick();
      b_awvalid = 1'b0; b_wvalid = 1'b0;
      chk("bw_c1", 32'(b_bvalid), 32'd0);
      tick();
      chk("bw_c2", 32'(b_bvalid), 32'd0);
      tick();
      chk("bw_c3", 32'(b_bvalid), 32'd1);
      b_bready = 1'b1; tick(); b_bready = 1'b0;
      chk("bw_after", 32'({b_awready, b_wready, b_bvalid}), 32'b110);

      b_arvalid = 1'b1; b_ardata = 32'h8;
      tick();
      b_arvalid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk("br_wait", 32'({b_arready, b_rvalid}), 32'b00);
         tick();
      end
      chk("br_c4_ctl", 32'({b_arready, b_rvalid}), 32'b01);
      chk("br_c4_data", b_rdata, 32'h600DF00D);
      tick();
      chk("br_hold", 32'({b_arready, b_rvalid}), 32'b01);
      b_rready = 1'b1; tick(); b_rready = 1'b0;
      chk("br_after", 32'({b_arready, b_rvalid}), 32'b10);

      // reset with dut_b in R_WAIT and dut_a holding only AW
      do_write(32'h40, 32'h12345678, 4'hF);
      AWvalid = 1'b1; AWdata = 32'h40; b_arvalid = 1'b1; b_ardata = 32'h8;
      tick();
      AWvalid = 1'b0; b_arvalid = 1'b0;
      resetn = 1'b0;
      Wvalid = 1'b1; Wdata = 32'hFFFFFFFF; Wstrb = 4'hF;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mid_rst_a", 32'({ARready, AWready, Wready, Rvalid, Bvalid}), 32'd0);
         chk("mid_rst_b", 32'({b_arready, b_awready, b_wready, b_rvalid, b_bvalid}), 32'd0);
         chk("mid_rst_rdata", Rdata | b_rdata, 32'd0);
      end
      Wvalid = 1'b0;
      resetn = 1'b1;
      tick();
      chk("rel_rdy", 32'({ARready, AWready, Wready, b_arready, b_awready, b_wready}), 32'h3F);
      for (int k = 0; k < 6; k++) begin
         chk("no_resp", 32'({Rvalid, Bvalid, b_rvalid, b_bvalid}), 32'd0);
         tick();
      end
      do_read(32'h40, rd);
      chk("rst_word_kept", rd, 32'h12345678);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
